ps2k_matrix: RTL and testbench

PS/2 scancode sequencer that turns the keyboard decoder's byte stream (strobe, code) into the 8×5 ZX Spectrum key matrix read by the ULA port. It consumes the decoder's byte strobes and tracks set-2 prefixes (E0, F0, E1). It maintains per-key pressed state and answers CPU row-select addresses with active-low column data. It also exposes F1–F12 hold state for machine control (reset, NMI, model switch).

---
 rtl/ps2k_pkg.sv | 43 ++++
 rtl/ps2k_map.sv | 115 +++++++++++
 rtl/ps2k_matrix.sv | 176 +++++++++++++++++
 tb/tb_ps2k_matrix.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2k_pkg.sv
// Shared types and constants for the PS/2 set-2 to ZX Spectrum matrix sequencer.
// Optional cursor/backspace combo keys are enabled by defining PS2K_COMBO_EN.
package ps2k_pkg;

   localparam int ROWS    = 8;
   localparam int COLS    = 5;
   localparam int FKEYS   = 12;
   localparam int COMBO_W = 5;

   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_E1 = 8'hE1;
   localparam logic [7:0] CODE_AA = 8'hAA;
   localparam logic [7:0] CODE_00 = 8'h00;
   localparam logic [7:0] CODE_FF = 8'hFF;
   localparam logic [7:0] CODE_FA = 8'hFA;
   localparam logic [7:0] CODE_FE = 8'hFE;
   localparam logic [7:0] CODE_EE = 8'hEE;
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_PAUSE  = 3'd4
   } state_e;

   typedef logic [ROWS-1:0][COLS-1:0] matrix_t;

   // True for bytes that wipe all key state (keyboard self-test pass, overrun, error).
   function automatic logic is_clear_code(input logic [7:0] c);
      return (c == CODE_AA) || (c == CODE_00) || (c == CODE_FF);
   endfunction

   function automatic logic is_ack_code(input logic [7:0] c);
      return (c == CODE_FA) || (c == CODE_FE) || (c == CODE_EE);
   endfunction

endpackage

// File: rtl/ps2k_map.sv
// Combinational {ext, code} to Spectrum matrix position / function-key decoder.
// Combo entries (cursor keys, backspace) exist only when PS2K_COMBO_EN is defined.
module ps2k_map
   import ps2k_pkg::*;
(
   input  logic       ext_i,
   input  logic [7:0] code_i,
   output logic       valid_o,
   output logic [2:0] row_o,
   output logic [2:0] col_o,
   output logic [3:0] fkey_idx_o,
   output logic       is_fkey_o
`ifdef PS2K_COMBO_EN
   ,
   output logic [COMBO_W-1:0] combo_o
`endif
);

   // Result format {hit, row, col}: 7'o1RC means row R, column C.
   function automatic logic [6:0] base_lookup(input logic [7:0] c);
      logic [6:0] r;
      case (c)
         8'h12: r = 7'o100;  8'h1A: r = 7'o101;  8'h22: r = 7'o102;
         8'h21: r = 7'o103;  8'h2A: r = 7'o104;
         8'h1C: r = 7'o110;  8'h1B: r = 7'o111;  8'h23: r = 7'o112;
         8'h2B: r = 7'o113;  8'h34: r = 7'o114;
         8'h15: r = 7'o120;  8'h1D: r = 7'o121;  8'h24: r = 7'o122;
         8'h2D: r = 7'o123;  8'h2C: r = 7'o124;
         8'h16: r = 7'o130;  8'h1E: r = 7'o131;  8'h26: r = 7'o132;
         8'h25: r = 7'o133;  8'h2E: r = 7'o134;
         8'h45: r = 7'o140;  8'h46: r = 7'o141;  8'h3E: r = 7'o142;
         8'h3D: r = 7'o143;  8'h36: r = 7'o144;
         8'h4D: r = 7'o150;  8'h44: r = 7'o151;  8'h43: r = 7'o152;
         8'h3C: r = 7'o153;  8'h35: r = 7'o154;
         8'h5A: r = 7'o160;  8'h4B: r = 7'o161;  8'h42: r = 7'o162;
         8'h3B: r = 7'o163;  8'h33: r = 7'o164;
         8'h29: r = 7'o170;  8'h59: r = 7'o171;  8'h14: r = 7'o171;
         8'h3A: r = 7'o172;  8'h31: r = 7'o173;  8'h32: r = 7'o174;
`ifdef PS2K_COMBO_EN
         8'h66: r = 7'o140;
`endif
         default: r = 7'o000;
      endcase
      return r;
   endfunction

   function automatic logic [6:0] ext_lookup(input logic [7:0] c);
      logic [6:0] r;
      case (c)
         8'h14: r = 7'o171;
         8'h5A: r = 7'o160;
`ifdef PS2K_COMBO_EN
         8'h6B: r = 7'o134;
         8'h72: r = 7'o144;
         8'h75: r = 7'o143;
         8'h74: r = 7'o142;
`endif
         default: r = 7'o000;
      endcase
      return r;
   endfunction

   // Result format {hit, fkey index}.
   function automatic logic [4:0] fkey_lookup(input logic [7:0] c);
      logic [4:0] r;
      case (c)
         8'h05: r = 5'h10;  8'h06: r = 5'h11;  8'h04: r = 5'h12;
         8'h0C: r = 5'h13;  8'h03: r = 5'h14;  8'h0B: r = 5'h15;
         8'h83: r = 5'h16;  8'h0A: r = 5'h17;  8'h01: r = 5'h18;
         8'h09: r = 5'h19;  8'h78: r = 5'h1A;  8'h07: r = 5'h1B;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

`ifdef PS2K_COMBO_EN
   function automatic logic [COMBO_W-1:0] combo_lookup(input logic e, input logic [7:0] c);
      logic [COMBO_W-1:0] r;
      case ({e, c})
         9'h066:  r = 5'b00001;
         9'h16B:  r = 5'b00010;
         9'h172:  r = 5'b00100;
         9'h175:  r = 5'b01000;
         9'h174:  r = 5'b10000;
         default: r = 5'b00000;
      endcase
      return r;
   endfunction
`endif

   logic [6:0] pos_s;
   logic [4:0] fk_s;

   // Select the lookup table for the current prefix context.
   always_comb begin
      pos_s = 7'o000;
      fk_s  = 5'h00;
      if (ext_i) begin
         pos_s = ext_lookup(code_i);
      end else begin
         pos_s = base_lookup(code_i);
         fk_s  = fkey_lookup(code_i);
      end
      is_fkey_o  = fk_s[4];
      fkey_idx_o = fk_s[3:0];
      valid_o    = pos_s[6] | fk_s[4];
      row_o      = pos_s[5:3];
      col_o      = pos_s[2:0];
   end

`ifdef PS2K_COMBO_EN
   assign combo_o = combo_lookup(ext_i, code_i);
`endif

endmodule

// File: rtl/ps2k_matrix.sv
// PS/2 set-2 scancode sequencer driving the 8x5 ZX Spectrum key matrix and F-key holds.
// Define PS2K_COMBO_EN to add cursor/backspace keys that also press CAPS SHIFT.
module ps2k_matrix
   import ps2k_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        strb,
   input  logic [7:0]  code,
   input  logic [7:0]  addr,
   output logic [4:0]  keys,
   output logic [11:0] fkey
);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   matrix_t          mat_q, mat_d;
   logic [FKEYS-1:0] fkey_q, fkey_d;
   logic [COLS-1:0]  keys_q, keys_d;

   logic       press_s, release_s, clear_s, ext_s;
   logic       map_valid_s, map_is_fkey_s;
   logic [2:0] map_row_s, map_col_s;
   logic [3:0] map_fkey_idx_s;
   matrix_t    eff_s;

`ifdef PS2K_COMBO_EN
   logic [COMBO_W-1:0] combo_q, combo_d, map_combo_s;
`endif

   assign ext_s = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

   ps2k_map u_map (
      .ext_i      (ext_s),
      .code_i     (code),
      .valid_o    (map_valid_s),
      .row_o      (map_row_s),
      .col_o      (map_col_s),
      .fkey_idx_o (map_fkey_idx_s),
      .is_fkey_o  (map_is_fkey_s)
`ifdef PS2K_COMBO_EN
      ,
      .combo_o    (map_combo_s)
`endif
   );

   // Prefix FSM: decides whether the strobed byte presses, releases, clears or is swallowed.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_s   = 1'b0;
      release_s = 1'b0;
      clear_s   = 1'b0;
      if (strb) begin
         case (state_q)
            ST_IDLE: begin
               if (code == CODE_E0) begin
                  state_d = ST_EXT;
               end else if (code == CODE_F0) begin
                  state_d = ST_BRK;
               end else if (code == CODE_E1) begin
                  state_d = ST_PAUSE;
                  cnt_d   = PAUSE_SKIP;
               end else if (is_clear_code(code)) begin
                  clear_s = 1'b1;
               end else if (is_ack_code(code)) begin
                  press_s = 1'b0;
               end else begin
                  press_s = 1'b1;
               end
            end
            ST_EXT: begin
               if (code == CODE_F0) begin
                  state_d = ST_EXTBRK;
               end else begin
                  state_d = ST_IDLE;
                  // E0 12 / E0 59 are synthetic shifts around nav keys.
                  press_s = (code != CODE_LSHIFT) && (code != CODE_RSHIFT);
               end
            end
            ST_BRK, ST_EXTBRK: begin
               release_s = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_PAUSE: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Key state update: clear wins, otherwise apply the mapped press/release.
   always_comb begin
      mat_d  = mat_q;
      fkey_d = fkey_q;
`ifdef PS2K_COMBO_EN
      combo_d = combo_q;
`endif
      if (clear_s) begin
         mat_d  = '0;
         fkey_d = '0;
`ifdef PS2K_COMBO_EN
         combo_d = '0;
`endif
      end else if ((press_s || release_s) && map_valid_s) begin
         if (map_is_fkey_s) begin
            fkey_d[map_fkey_idx_s] = press_s;
         end else begin
            mat_d[map_row_s][map_col_s] = press_s;
         end
`ifdef PS2K_COMBO_EN
         if (press_s) begin
            combo_d = combo_q | map_combo_s;
         end else begin
            combo_d = combo_q & ~map_combo_s;
         end
`endif
      end else begin
         mat_d = mat_q;
      end
   end

   // Row readout with CAPS merged from any held combo key.
   always_comb begin
      eff_s = mat_q;
`ifdef PS2K_COMBO_EN
      eff_s[0][0] = mat_q[0][0] | (|combo_q);
`endif
      keys_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (!addr[r]) begin
            keys_d = keys_d | eff_s[r];
         end else begin
            keys_d = keys_d;
         end
      end
      keys_d = ~keys_d;
   end

   // State, matrix and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         mat_q   <= '0;
         fkey_q  <= '0;
         keys_q  <= 5'h1F;
`ifdef PS2K_COMBO_EN
         combo_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mat_q   <= mat_d;
         fkey_q  <= fkey_d;
         keys_q  <= keys_d;
`ifdef PS2K_COMBO_EN
         combo_q <= combo_d;
`endif
      end
   end

   assign keys = keys_q;
   assign fkey = fkey_q;

endmodule

// File: tb/tb_ps2k_matrix.sv
// Directed self-checking bench for ps2k_matrix; expectations follow PS2K_COMBO_EN.
module tb_ps2k_matrix;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        strb  = 1'b0;
   logic [7:0]  code  = 8'h00;
   logic [7:0]  addr  = 8'hFF;
   logic [4:0]  keys;
   logic [11:0] fkey;

   int checks = 0;
   int errors = 0;

   ps2k_matrix dut (
      .clock (clock),
      .reset (reset),
      .strb  (strb),
      .code  (code),
      .addr  (addr),
      .keys  (keys),
      .fkey  (fkey)
   );

   always #5 clock = ~clock;

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      strb = 1'b1;
      code = b;
      @(negedge clock);
      strb = 1'b0;
      code = 8'h00;
   endtask

   task automatic rd(input logic [7:0] a, output logic [4:0] k);
      @(negedge clock);
      addr = a;
      @(negedge clock);
      k = keys;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] k;
      @(negedge clock);
      addr  = 8'h00;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (keys !== 5'h1F) begin errors++; $display("FAIL reset_keys got=%h exp=%h", keys, 5'h1F); end
      checks++;
      if (fkey !== 12'h000) begin errors++; $display("FAIL reset_fkey got=%h exp=%h", fkey, 12'h000); end
      reset = 1'b0;
      rd(8'h00, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL reset_all_rows got=%h exp=%h", k, 5'h1F); end
   endtask

   task automatic test_press_release();
      logic [4:0] k;
      do_reset();
      send(8'h1C);
      rd(8'hFD, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL press_a got=%h exp=%h", k, 5'h1E); end
      send(8'h1C);
      rd(8'hFD, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL typematic_a got=%h exp=%h", k, 5'h1E); end
      send(8'hF0); send(8'h1C);
      rd(8'hFD, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL release_a got=%h exp=%h", k, 5'h1F); end
      send(8'h2A);
      rd(8'hFE, k);
      checks++;
      if (k !== 5'h0F) begin errors++; $display("FAIL press_v got=%h exp=%h", k, 5'h0F); end
      send(8'hF0); send(8'h2A);
   endtask

   task automatic test_latency();
      do_reset();
      @(negedge clock);
      addr = 8'hFD;
      send(8'h1C);
      checks++;
      if (keys !== 5'h1F) begin errors++; $display("FAIL latency_early got=%h exp=%h", keys, 5'h1F); end
      @(negedge clock);
      checks++;
      if (keys !== 5'h1E) begin errors++; $display("FAIL latency_n2 got=%h exp=%h", keys, 5'h1E); end
   endtask

   task automatic test_shift_rows();
      logic [4:0] k;
      do_reset();
      send(8'h12); send(8'h1C);
      rd(8'hFC, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL caps_a_fc got=%h exp=%h", k, 5'h1E); end
      rd(8'hFE, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL caps_fe got=%h exp=%h", k, 5'h1E); end
      rd(8'h7F, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL row7_empty got=%h exp=%h", k, 5'h1F); end
      send(8'h14); send(8'h16);
      rd(8'h7F, k);
      checks++;
      if (k !== 5'h1D) begin errors++; $display("FAIL ctrl_sym got=%h exp=%h", k, 5'h1D); end
      rd(8'hF5, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL multi_row got=%h exp=%h", k, 5'h1E); end
      rd(8'hFF, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL addr_ff got=%h exp=%h", k, 5'h1F); end
      send(8'hE0); send(8'h12);
      send(8'hF0); send(8'h12);
      send(8'hE0); send(8'h12);
      rd(8'hFE, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL fake_shift got=%h exp=%h", k, 5'h1F); end
      send(8'hFA);
      rd(8'h00, k);
      checks++;
      if (k !== 5'h1C) begin errors++; $display("FAIL ack_ignored got=%h exp=%h", k, 5'h1C); end
   endtask

   task automatic test_pause();
      logic [4:0] k;
      do_reset();
      send(8'hE1); send(8'h14);
      rd(8'h7F, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL pause_mid got=%h exp=%h", k, 5'h1F); end
      send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      rd(8'h00, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL pause_end got=%h exp=%h", k, 5'h1F); end
      send(8'h29);
      rd(8'h7F, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL after_pause got=%h exp=%h", k, 5'h1E); end
   endtask

   task automatic test_combo();
      logic [4:0] k;
      do_reset();
      send(8'h12);
      send(8'hE0); send(8'h75);
      rd(8'hEF, k);
`ifdef PS2K_COMBO_EN
      checks++;
      if (k !== 5'h17) begin errors++; $display("FAIL combo_up_7 got=%h exp=%h", k, 5'h17); end
`else
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL nocombo_up got=%h exp=%h", k, 5'h1F); end
`endif
      send(8'hE0); send(8'hF0); send(8'h75);
      rd(8'hFE, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL combo_caps_held got=%h exp=%h", k, 5'h1E); end
      rd(8'hEF, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL combo_7_released got=%h exp=%h", k, 5'h1F); end
      send(8'hF0); send(8'h12);
      send(8'hE0); send(8'h6B);
      rd(8'hFE, k);
`ifdef PS2K_COMBO_EN
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL combo_left_caps got=%h exp=%h", k, 5'h1E); end
      rd(8'hF7, k);
      checks++;
      if (k !== 5'h0F) begin errors++; $display("FAIL combo_left_5 got=%h exp=%h", k, 5'h0F); end
`else
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL nocombo_left got=%h exp=%h", k, 5'h1F); end
`endif
      send(8'hE0); send(8'hF0); send(8'h6B);
      send(8'h66);
      rd(8'hEE, k);
`ifdef PS2K_COMBO_EN
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL combo_bksp got=%h exp=%h", k, 5'h1E); end
`else
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL nocombo_bksp got=%h exp=%h", k, 5'h1F); end
`endif
      send(8'hF0); send(8'h66);
      rd(8'hEE, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL bksp_release got=%h exp=%h", k, 5'h1F); end
   endtask

   task automatic test_fkey();
      do_reset();
      send(8'h05);
      checks++;
      if (fkey !== 12'h001) begin errors++; $display("FAIL f1_down got=%h exp=%h", fkey, 12'h001); end
      send(8'hF0); send(8'h05);
      checks++;
      if (fkey !== 12'h000) begin errors++; $display("FAIL f1_up got=%h exp=%h", fkey, 12'h000); end
      send(8'h0C);
      checks++;
      if (fkey !== 12'h008) begin errors++; $display("FAIL f4_down got=%h exp=%h", fkey, 12'h008); end
      send(8'h07);
      checks++;
      if (fkey !== 12'h808) begin errors++; $display("FAIL f12_down got=%h exp=%h", fkey, 12'h808); end
      send(8'h83);
      checks++;
      if (fkey !== 12'h848) begin errors++; $display("FAIL f7_down got=%h exp=%h", fkey, 12'h848); end
   endtask

   task automatic test_clear();
      logic [4:0] k;
      logic [7:0] alist [5];
      alist = '{8'h00, 8'hF7, 8'hFE, 8'h7F, 8'hFF};
      do_reset();
      send(8'h16); send(8'h05);
      rd(8'hF7, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL pre_clear got=%h exp=%h", k, 5'h1E); end
      send(8'hAA);
      checks++;
      if (fkey !== 12'h000) begin errors++; $display("FAIL clear_fkey got=%h exp=%h", fkey, 12'h000); end
      for (int i = 0; i < 5; i++) begin
         rd(alist[i], k);
         checks++;
         if (k !== 5'h1F) begin errors++; $display("FAIL clear_row a=%h got=%h exp=%h", alist[i], k, 5'h1F); end
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] k;
      do_reset();
      send(8'h16);
      send(8'hF0);
      do_reset();
      send(8'h16);
      rd(8'hF7, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL reset_in_brk got=%h exp=%h", k, 5'h1E); end
      send(8'hE1);
      do_reset();
      send(8'h1C);
      rd(8'hFD, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL reset_in_pause got=%h exp=%h", k, 5'h1E); end
      rd(8'hF7, k);
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL reset_cleared_1 got=%h exp=%h", k, 5'h1F); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] k;
      do_reset();
      send(8'h1C);
      @(negedge clock);
      strb = 1'b1; code = 8'hF0;
      @(negedge clock);
      code = 8'h1C;
      @(negedge clock);
      code = 8'hE0;
      @(negedge clock);
      code = 8'h5A;
      @(negedge clock);
      strb = 1'b0; code = 8'h00;
      rd(8'hFD, k);
      checks++;
      if (k !== 5'h1E && k !== 5'h1F) begin errors++; $display("FAIL b2b_bad got=%h exp=%h", k, 5'h1F); end
      checks++;
      if (k !== 5'h1F) begin errors++; $display("FAIL b2b_release got=%h exp=%h", k, 5'h1F); end
      rd(8'hBF, k);
      checks++;
      if (k !== 5'h1E) begin errors++; $display("FAIL b2b_ext_enter got=%h exp=%h", k, 5'h1E); end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_latency();
      test_shift_rows();
      test_pause();
      test_combo();
      test_fkey();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
